// File: rtl/z80fi_insn_collector.sv
// Packs the bytes of one Z80 instruction LSB-first and hands the packed word, its length and
// its start IP to the downstream spec checkers through a one-deep registered output.
module z80fi_insn_collector #(
   parameter int unsigned MAX_LEN = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 byte_valid,
   input  logic [7:0]           byte_data,
   input  logic [15:0]          byte_ip,
   input  logic                 insn_done,
   input  logic                 insn_abort,
   input  logic                 z80fi_ready,
   output logic                 z80fi_valid,
   output logic [8*MAX_LEN-1:0] z80fi_insn,
   output logic [2:0]           z80fi_insn_len,
   output logic [15:0]          z80fi_reg_ip_in,
   output logic                 too_long,
   output logic                 overrun
);

   localparam int unsigned W       = 8 * MAX_LEN;
   localparam logic [2:0]  LEN_MAX = 3'(MAX_LEN);

   typedef enum logic {StIdle, StCollect} state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [2:0]      len_q, len_d;
   logic [15:0]     ip_q, ip_d;
   logic            valid_q, valid_d;
   logic [W-1:0]    insn_q, insn_d;
   logic [2:0]      olen_q, olen_d;
   logic [15:0]     oip_q, oip_d;
   logic            too_long_q, too_long_d;
   logic            overrun_q, overrun_d;
   logic            emit;

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      len_d      = len_q;
      ip_d       = ip_q;
      valid_d    = valid_q;
      insn_d     = insn_q;
      olen_d     = olen_q;
      oip_d      = oip_q;
      too_long_d = too_long_q;
      overrun_d  = overrun_q;
      emit       = 1'b0;

      if (insn_abort) begin
         state_d = StIdle;
         acc_d   = '0;
         len_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (byte_valid) begin
                  acc_d = '0;
                  acc_d[7:0] = byte_data;
                  len_d = 3'd1;
                  ip_d  = byte_ip;
                  if (insn_done) begin
                     emit    = 1'b1;
                     state_d = StIdle;
                  end else begin
                     state_d = StCollect;
                  end
               end
            end
            StCollect: begin
               if (byte_valid) begin
                  if (len_q < LEN_MAX) begin
                     for (int k = 0; k < int'(MAX_LEN); k++) begin
                        if (len_q == 3'(k)) acc_d[8*k +: 8] = byte_data;
                     end
                     len_d = len_q + 3'd1;
                  end else begin
                     too_long_d = 1'b1;
                  end
               end
               if (insn_done) begin
                  emit    = 1'b1;
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end

      // Emission uses the post-update accumulator so a byte arriving with done is included.
      if (emit) begin
         if (!valid_q || z80fi_ready) begin
            valid_d = 1'b1;
            insn_d  = acc_d;
            olen_d  = len_d;
            oip_d   = ip_d;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && z80fi_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         acc_q      <= '0;
         len_q      <= '0;
         ip_q       <= '0;
         valid_q    <= 1'b0;
         insn_q     <= '0;
         olen_q     <= '0;
         oip_q      <= '0;
         too_long_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         len_q      <= len_d;
         ip_q       <= ip_d;
         valid_q    <= valid_d;
         insn_q     <= insn_d;
         olen_q     <= olen_d;
         oip_q      <= oip_d;
         too_long_q <= too_long_d;
         overrun_q  <= overrun_d;
      end
   end

   assign z80fi_valid     = valid_q;
   assign z80fi_insn      = insn_q;
   assign z80fi_insn_len  = olen_q;
   assign z80fi_reg_ip_in = oip_q;
   assign too_long        = too_long_q;
   assign overrun         = overrun_q;

endmodule

// File: tb/tb_z80fi_insn_collector.sv
// Directed bench for z80fi_insn_collector: expected instructions are queued as stimulus is
// driven and popped when the DUT presents its output.
module tb_z80fi_insn_collector;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = '0;
   logic [15:0] byte_ip = '0;
   logic        insn_done = 1'b0;
   logic        insn_abort = 1'b0;
   logic        z80fi_ready = 1'b1;
   logic        z80fi_valid;
   logic [31:0] z80fi_insn;
   logic [2:0]  z80fi_insn_len;
   logic [15:0] z80fi_reg_ip_in;
   logic        too_long;
   logic        overrun;

   typedef struct packed {
      logic [31:0] insn;
      logic [2:0]  len;
      logic [15:0] ip;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   checks = 0;
   int   passes = 0;

   z80fi_insn_collector #(.MAX_LEN(4)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .byte_valid      (byte_valid),
      .byte_data       (byte_data),
      .byte_ip         (byte_ip),
      .insn_done       (insn_done),
      .insn_abort      (insn_abort),
      .z80fi_ready     (z80fi_ready),
      .z80fi_valid     (z80fi_valid),
      .z80fi_insn      (z80fi_insn),
      .z80fi_insn_len  (z80fi_insn_len),
      .z80fi_reg_ip_in (z80fi_reg_ip_in),
      .too_long        (too_long),
      .overrun         (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of inputs, then sample just after the edge.
   task automatic cyc(input logic bv, input logic [7:0] bd, input logic [15:0] ip,
                      input logic done, input logic abort);
      byte_valid = bv;
      byte_data  = bd;
      byte_ip    = ip;
      insn_done  = done;
      insn_abort = abort;
      step();
      byte_valid = 1'b0;
      insn_done  = 1'b0;
      insn_abort = 1'b0;
   endtask

   task automatic expect_out(input string tag);
      int n = 0;
      while (!z80fi_valid && n < 8) begin
         step();
         n++;
      end
      cur = sb.pop_front();
      chk({tag, "_valid"}, 32'(z80fi_valid), 32'd1);
      chk({tag, "_insn"}, z80fi_insn, cur.insn);
      chk({tag, "_len"}, 32'(z80fi_insn_len), 32'(cur.len));
      chk({tag, "_ip"}, 32'(z80fi_reg_ip_in), 32'(cur.ip));
   endtask

   initial begin
      #2;
      chk("rst_valid", 32'(z80fi_valid), 32'd0);
      chk("rst_insn", z80fi_insn, 32'd0);
      chk("rst_len", 32'(z80fi_insn_len), 32'd0);
      chk("rst_flags", {30'd0, too_long, overrun}, 32'd0);
      #11 reset_n = 1'b1;
      step();

      // 1: DD CB 05 C6, done with the last byte
      cyc(1'b1, 8'hDD, 16'h1000, 1'b0, 1'b0);
      cyc(1'b1, 8'hCB, 16'h1001, 1'b0, 1'b0);
      cyc(1'b1, 8'h05, 16'h1002, 1'b0, 1'b0);
      chk("t1_not_yet", 32'(z80fi_valid), 32'd0);
      sb.push_back('{insn: 32'hC605CBDD, len: 3'd4, ip: 16'h1000});
      cyc(1'b1, 8'hC6, 16'h1003, 1'b1, 1'b0);
      expect_out("t1");
      chk("t1_too_long", 32'(too_long), 32'd0);
      chk("t1_overrun", 32'(overrun), 32'd0);
      step();
      chk("t1_valid_drop", 32'(z80fi_valid), 32'd0);

      // 2: single byte with done in IDLE at ip FFFF
      sb.push_back('{insn: 32'h0, len: 3'd1, ip: 16'hFFFF});
      cyc(1'b1, 8'h00, 16'hFFFF, 1'b1, 1'b0);
      expect_out("t2");
      step();

      // 3: five bytes, the fifth dropped
      cyc(1'b1, 8'h11, 16'h2000, 1'b0, 1'b0);
      cyc(1'b1, 8'h22, 16'h2001, 1'b0, 1'b0);
      cyc(1'b1, 8'h33, 16'h2002, 1'b0, 1'b0);
      cyc(1'b1, 8'h44, 16'h2003, 1'b0, 1'b0);
      cyc(1'b1, 8'h55, 16'h2004, 1'b0, 1'b0);
      chk("t3_too_long", 32'(too_long), 32'd1);
      sb.push_back('{insn: 32'h44332211, len: 3'd4, ip: 16'h2000});
      cyc(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
      expect_out("t3");
      step();

      // 4: hold with ready low, overrun, then replacement with ready high
      z80fi_ready = 1'b0;
      cyc(1'b1, 8'hAA, 16'h3000, 1'b0, 1'b0);
      sb.push_back('{insn: 32'h0000BBAA, len: 3'd2, ip: 16'h3000});
      cyc(1'b1, 8'hBB, 16'h3001, 1'b1, 1'b0);
      expect_out("t4a");
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_hold_valid", 32'(z80fi_valid), 32'd1);
         chk("t4_hold_insn", z80fi_insn, cur.insn);
         chk("t4_hold_len", 32'(z80fi_insn_len), 32'(cur.len));
      end
      chk("t4_no_overrun", 32'(overrun), 32'd0);
      cyc(1'b1, 8'h01, 16'h4000, 1'b1, 1'b0);
      chk("t4_overrun", 32'(overrun), 32'd1);
      chk("t4_kept_insn", z80fi_insn, cur.insn);
      chk("t4_kept_ip", 32'(z80fi_reg_ip_in), 32'(cur.ip));
      z80fi_ready = 1'b1;
      sb.push_back('{insn: 32'h00000002, len: 3'd1, ip: 16'h5000});
      cyc(1'b1, 8'h02, 16'h5000, 1'b1, 1'b0);
      expect_out("t4b");
      chk("t4_overrun_stays", 32'(overrun), 32'd1);
      step();
      chk("t4_valid_drop", 32'(z80fi_valid), 32'd0);

      // 5: abort discards partial bytes
      cyc(1'b1, 8'hDD, 16'h6000, 1'b0, 1'b0);
      cyc(1'b1, 8'h21, 16'h6001, 1'b0, 1'b0);
      cyc(1'b1, 8'h99, 16'h6002, 1'b1, 1'b1);
      chk("t5_abort_no_emit", 32'(z80fi_valid), 32'd0);
      cyc(1'b1, 8'h3E, 16'h6010, 1'b0, 1'b0);
      sb.push_back('{insn: 32'h00007F3E, len: 3'd2, ip: 16'h6010});
      cyc(1'b1, 8'h7F, 16'h6011, 1'b1, 1'b0);
      expect_out("t5");
      step();

      // 6: asynchronous reset while holding output and mid-collection
      z80fi_ready = 1'b0;
      sb.push_back('{insn: 32'h00000010, len: 3'd1, ip: 16'h7000});
      cyc(1'b1, 8'h10, 16'h7000, 1'b1, 1'b0);
      expect_out("t6a");
      cyc(1'b1, 8'h20, 16'h7001, 1'b0, 1'b0);
      cyc(1'b1, 8'h30, 16'h7002, 1'b0, 1'b0);
      #1 reset_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(z80fi_valid), 32'd0);
      chk("t6_rst_insn", z80fi_insn, 32'd0);
      chk("t6_rst_len_ip", {13'd0, z80fi_insn_len, z80fi_reg_ip_in}, 32'd0);
      chk("t6_rst_flags", {30'd0, too_long, overrun}, 32'd0);
      #2 reset_n = 1'b1;
      z80fi_ready = 1'b1;
      step();
      sb.push_back('{insn: 32'h00000076, len: 3'd1, ip: 16'h7100});
      cyc(1'b1, 8'h76, 16'h7100, 1'b1, 1'b0);
      expect_out("t6b");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
